clock_div_multi: RTL and testbench

//  N_CH-channel runtime-programmable integer clock divider. Generalises the fixed /2,/4,/8,/16,/28,/5 dividers.

---
 rtl/clock_div_multi_pkg.sv | 18 +
 rtl/clock_div_multi_channel.sv | 99 +++++++++
 rtl/clock_div_multi.sv | 73 +++++++
 tb/tb_clock_div_multi.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_div_multi_pkg.sv
// Shared constants and types for the multi-channel programmable clock divider.
package clock_div_multi_pkg;

  localparam int MIN_DIV   = 2;
  localparam int DEF_DIV_W = 8;
  localparam int DEF_N_CH  = 4;

  typedef enum logic [1:0] {
    CFG_OK      = 2'b00,
    CFG_BAD_DIV = 2'b01,
    CFG_BAD_CH  = 2'b10
  } cfg_status_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_div_multi_channel.sv
// One divider channel: period counter, active/shadow divisor, 50%-duty clock
// built from a posedge term and its negedge copy, and a period-start strobe.
module clock_div_multi_channel #(
  parameter int   DIV_W   = 8,
  parameter int   RST_DIV = 4,
  parameter logic RST_EN  = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wdata,
  output logic             pending,
  output logic             clk_out,
  output logic             strobe
);

  localparam logic [DIV_W-1:0] RST_D = DIV_W'(RST_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nx;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] active_nx;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] shadow_nx;
  logic [DIV_W:0]   half_nx;
  logic             pending_nx;
  logic             pos_q;
  logic             pos_nx;
  logic             neg_q;
  logic             strobe_nx;
  logic             run;
  logic             armed;
  logic             live;

  // A channel held idle after reset (RST_EN=0) is armed by the first sync.
  assign live = en & (armed | sync);

  // Next count and divisor; the new divisor only takes effect at a wrap or sync.
  always_comb begin
    shadow_nx  = wr ? wdata : shadow;
    active_nx  = active;
    pending_nx = pending | wr;
    cnt_nx     = {DIV_W{1'b0}};
    if (!live) begin
      cnt_nx = {DIV_W{1'b0}};
    end else if (sync) begin
      active_nx  = shadow_nx;
      pending_nx = 1'b0;
    end else if (!run) begin
      cnt_nx = {DIV_W{1'b0}};
    end else if (cnt == active - ONE) begin
      active_nx  = shadow_nx;
      pending_nx = 1'b0;
    end else begin
      cnt_nx = cnt + ONE;
    end
    half_nx   = ({1'b0, active_nx} + {{DIV_W{1'b0}}, 1'b1}) >> 1'b1;
    pos_nx    = live & ({1'b0, cnt_nx} < half_nx);
    strobe_nx = live & (cnt_nx == {DIV_W{1'b0}});
  end

  // Channel state register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= {DIV_W{1'b0}};
      active  <= RST_D;
      shadow  <= RST_D;
      pending <= 1'b0;
      pos_q   <= 1'b0;
      strobe  <= 1'b0;
      run     <= 1'b0;
      armed   <= RST_EN;
    end else begin
      cnt     <= cnt_nx;
      active  <= active_nx;
      shadow  <= shadow_nx;
      pending <= pending_nx;
      pos_q   <= pos_nx;
      strobe  <= strobe_nx;
      run     <= live;
      armed   <= armed | sync;
    end
  end

  // Half-cycle delayed copy of pos_q; trims the high phase for odd divisors.
  always_ff @(negedge clk_in) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clk_out = active[0] ? (pos_q & neg_q) : pos_q;

endmodule

// File: rtl/clock_div_multi.sv
// N_CH-channel runtime-programmable integer clock divider with shared
// configuration port and rejected-write reporting.
module clock_div_multi
  import clock_div_multi_pkg::*;
#(
  parameter int   N_CH    = DEF_N_CH,
  parameter int   CH_W    = ch_width(N_CH),
  parameter int   DIV_W   = DEF_DIV_W,
  parameter int   RST_DIV = 4,
  parameter logic RST_EN  = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  strobe
);

  localparam logic [CH_W:0]    N_CH_L = (CH_W+1)'(N_CH);
  localparam logic [DIV_W-1:0] MIN_D  = DIV_W'(MIN_DIV);

  cfg_status_e status;
  logic        cfg_ok;

  // Classify the configuration write.
  always_comb begin
    if (cfg_div < MIN_D) begin
      status = CFG_BAD_DIV;
    end else if ({1'b0, cfg_ch} >= N_CH_L) begin
      status = CFG_BAD_CH;
    end else begin
      status = CFG_OK;
    end
  end

  assign cfg_ok = cfg_we & (status == CFG_OK);

  // One-cycle rejection pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & (status != CFG_OK);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    clock_div_multi_channel #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV),
      .RST_EN  (RST_EN)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr      (cfg_ok & (cfg_ch == IDX)),
      .wdata   (cfg_div),
      .pending (pending[i]),
      .clk_out (clk_out[i]),
      .strobe  (strobe[i])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench for clock_div_multi: directed scenarios plus random
// traffic, compared against a period/phase reference model.
module tb_clock_div_multi;

  localparam int N_CH    = 3;
  localparam int CH_W    = 2;
  localparam int DIV_W   = 8;
  localparam int RST_DIV = 4;
  localparam int VW      = 3*N_CH + 1;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  strobe;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: phase within current period, divisors, pending flag
  int m_ph   [N_CH];
  int m_dact [N_CH];
  int m_dsh  [N_CH];
  bit m_pend [N_CH];
  bit m_run  [N_CH];
  bit m_lvl  [N_CH];
  logic [N_CH-1:0] e_strobe, e_first, e_second, e_pend;
  logic            e_err;
  logic [VW-1:0]   got, exp_v;

  clock_div_multi #(
    .N_CH(N_CH), .CH_W(CH_W), .DIV_W(DIV_W), .RST_DIV(RST_DIV), .RST_EN(1'b1)
  ) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err), .pending(pending),
    .clk_out(clk_out), .strobe(strobe)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_edge();
    bit wr;
    bit hi;
    e_err = !rst && cfg_we && (cfg_div < 8'd2 || int'(cfg_ch) >= N_CH);
    for (int i = 0; i < N_CH; i++) begin
      if (rst) begin
        m_ph[i] = 0; m_dact[i] = RST_DIV; m_dsh[i] = RST_DIV;
        m_pend[i] = 1'b0; m_run[i] = 1'b0; m_lvl[i] = 1'b0;
        e_strobe[i] = 1'b0; e_first[i] = 1'b0; e_second[i] = 1'b0; e_pend[i] = 1'b0;
      end else begin
        wr = cfg_we && cfg_div >= 8'd2 && int'(cfg_ch) == i;
        if (wr) begin
          m_dsh[i]  = int'(cfg_div);
          m_pend[i] = 1'b1;
        end
        if (!en[i]) begin
          m_run[i] = 1'b0; m_lvl[i] = 1'b0;
          e_strobe[i] = 1'b0; e_first[i] = 1'b0; e_second[i] = 1'b0;
        end else begin
          if (sync || (m_run[i] && m_ph[i] + 1 == m_dact[i])) begin
            m_ph[i] = 0; m_dact[i] = m_dsh[i]; m_pend[i] = 1'b0;
          end else if (!m_run[i]) begin
            m_ph[i] = 0;
          end else begin
            m_ph[i]++;
          end
          m_run[i] = 1'b1;
          // high for ceil(D/2) cycles; odd D loses the first half-cycle
          hi = m_ph[i] < (m_dact[i] + 1) / 2;
          e_strobe[i] = (m_ph[i] == 0);
          e_first[i]  = (m_dact[i] % 2 == 1) ? (hi && m_lvl[i]) : hi;
          e_second[i] = hi;
          m_lvl[i]    = hi;
        end
        e_pend[i] = m_pend[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 16; c++) begin
      rst = (c < 3);
      tick();
      got = {strobe, clk_out, pending, cfg_err}; exp_v = {e_strobe, e_first, e_pend, e_err};
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, got, exp_v); end
      n_checks++;
      if (strobe[0] !== ((c >= 3) && ((c - 3) % 4 == 0))) begin
        n_fail++; $display("FAIL reset_strobe0 cyc=%0d got=%b exp=%b", cyc, strobe[0], (c >= 3) && ((c - 3) % 4 == 0));
      end
      @(negedge clk_in); #1;
      n_checks++; if (clk_out !== e_second) begin n_fail++; $display("FAIL reset_neg cyc=%0d got=%b exp=%b", cyc, clk_out, e_second); end
    end
  endtask

  task automatic test_odd_div();
    int q[$];
    for (int c = 0; c < 25; c++) begin
      cfg_we = (c == 0); cfg_ch = 2'd1; cfg_div = 8'd5;
      tick();
      if (strobe[1]) q.push_back(cyc);
      got = {strobe, clk_out, pending, cfg_err}; exp_v = {e_strobe, e_first, e_pend, e_err};
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL odd_model cyc=%0d got=%b exp=%b", cyc, got, exp_v); end
      @(negedge clk_in); #1;
      n_checks++; if (clk_out !== e_second) begin n_fail++; $display("FAIL odd_neg cyc=%0d got=%b exp=%b", cyc, clk_out, e_second); end
    end
    cfg_we = 1'b0;
    n_checks++;
    if (q.size() < 3) begin
      n_fail++; $display("FAIL odd_period strobes=%0d need>=3", q.size());
    end else if (q[q.size()-1] - q[q.size()-2] != 5) begin
      n_fail++; $display("FAIL odd_period got=%0d exp=5", q[q.size()-1] - q[q.size()-2]);
    end
  endtask

  task automatic test_div_change();
    int guard = 0;
    while (m_ph[0] != 1 && guard < 12) begin
      tick(); @(negedge clk_in); #1; guard++;
    end
    n_checks++; if (guard >= 12) begin n_fail++; $display("FAIL chg_find_cnt1 got=timeout exp=cnt1"); end
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6;
    for (int k = 0; k < 16; k++) begin
      tick();
      cfg_we = 1'b0;
      got = {strobe, clk_out, pending, cfg_err}; exp_v = {e_strobe, e_first, e_pend, e_err};
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL chg_model cyc=%0d got=%b exp=%b", cyc, got, exp_v); end
      n_checks++;
      if (strobe[0] !== (k == 2 || k == 8 || k == 14)) begin
        n_fail++; $display("FAIL chg_strobe0 k=%0d got=%b exp=%b", k, strobe[0], (k == 2 || k == 8 || k == 14));
      end
      if (k == 0 || k == 2) begin
        n_checks++;
        if (pending[0] !== (k == 0)) begin n_fail++; $display("FAIL chg_pending k=%0d got=%b exp=%b", k, pending[0], k == 0); end
      end
      @(negedge clk_in); #1;
      n_checks++; if (clk_out !== e_second) begin n_fail++; $display("FAIL chg_neg cyc=%0d got=%b exp=%b", cyc, clk_out, e_second); end
    end
  endtask

  task automatic test_cfg_err();
    for (int c = 0; c < 6; c++) begin
      cfg_we  = (c == 0 || c == 2);
      cfg_ch  = (c == 2) ? 2'd3 : 2'd0;
      cfg_div = (c == 2) ? 8'd5 : 8'd1;
      tick();
      got = {strobe, clk_out, pending, cfg_err}; exp_v = {e_strobe, e_first, e_pend, e_err};
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL err_model cyc=%0d got=%b exp=%b", cyc, got, exp_v); end
      n_checks++;
      if (cfg_err !== (c == 0 || c == 2)) begin n_fail++; $display("FAIL err_pulse c=%0d got=%b exp=%b", c, cfg_err, c == 0 || c == 2); end
      n_checks++; if (pending !== 3'b000) begin n_fail++; $display("FAIL err_pending c=%0d got=%b exp=000", c, pending); end
      @(negedge clk_in); #1;
      n_checks++; if (clk_out !== e_second) begin n_fail++; $display("FAIL err_neg cyc=%0d got=%b exp=%b", cyc, clk_out, e_second); end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_sync();
    int sc = int'($urandom_range(10, 16));
    for (int c = 0; c < 24; c++) begin
      cfg_we  = (c < 2);
      cfg_ch  = (c == 0) ? 2'd1 : 2'd0;
      cfg_div = (c == 0) ? 8'd6 : 8'd4;
      sync    = (c == sc);
      tick();
      got = {strobe, clk_out, pending, cfg_err}; exp_v = {e_strobe, e_first, e_pend, e_err};
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL sync_model cyc=%0d got=%b exp=%b", cyc, got, exp_v); end
      if (c == sc) begin
        n_checks++; if (strobe !== 3'b111) begin n_fail++; $display("FAIL sync_strobe got=%b exp=111", strobe); end
        n_checks++; if (clk_out !== 3'b111) begin n_fail++; $display("FAIL sync_clk got=%b exp=111", clk_out); end
      end
      @(negedge clk_in); #1;
      n_checks++; if (clk_out !== e_second) begin n_fail++; $display("FAIL sync_neg cyc=%0d got=%b exp=%b", cyc, clk_out, e_second); end
    end
    sync = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_rst_disable();
    int guard = 0;
    while (m_ph[0] != 1 && guard < 12) begin
      tick(); @(negedge clk_in); #1; guard++;
    end
    n_checks++; if (guard >= 12) begin n_fail++; $display("FAIL rst_find_cnt1 got=timeout exp=cnt1"); end
    for (int c = 0; c < 14; c++) begin
      cfg_we = (c == 0); cfg_ch = 2'd0; cfg_div = 8'd8;
      rst    = (c == 1);
      en     = (c >= 3) ? 3'b011 : 3'b111;
      tick();
      got = {strobe, clk_out, pending, cfg_err}; exp_v = {e_strobe, e_first, e_pend, e_err};
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL rst_model cyc=%0d got=%b exp=%b", cyc, got, exp_v); end
      if (c == 0) begin
        n_checks++; if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pend_before got=%b exp=1", pending[0]); end
      end
      if (c == 1) begin
        n_checks++;
        if ({strobe, clk_out, pending} !== 9'd0) begin n_fail++; $display("FAIL rst_mid got=%b exp=0", {strobe, clk_out, pending}); end
      end
      if (c == 2) begin
        n_checks++; if (clk_out[2] !== 1'b1) begin n_fail++; $display("FAIL rst_ch2_high got=%b exp=1", clk_out[2]); end
      end
      if (c == 3) begin
        n_checks++; if (clk_out[2] !== 1'b0) begin n_fail++; $display("FAIL dis_ch2 got=%b exp=0", clk_out[2]); end
      end
      if (c == 6) begin
        n_checks++; if (strobe[0] !== 1'b1) begin n_fail++; $display("FAIL rst_div_default got=%b exp=1", strobe[0]); end
      end
      @(negedge clk_in); #1;
      n_checks++; if (clk_out !== e_second) begin n_fail++; $display("FAIL rst_neg cyc=%0d got=%b exp=%b", cyc, clk_out, e_second); end
    end
    rst = 1'b0; cfg_we = 1'b0; en = 3'b111;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_CH; i++) if ($urandom_range(0, 31) == 0) en[i] = ~en[i];
      cfg_we  = ($urandom_range(0, 5) == 0);
      cfg_ch  = CH_W'($urandom_range(0, 3));
      cfg_div = DIV_W'($urandom_range(0, 12));
      sync    = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      tick();
      got = {strobe, clk_out, pending, cfg_err}; exp_v = {e_strobe, e_first, e_pend, e_err};
      n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", cyc, got, exp_v); end
      @(negedge clk_in); #1;
      n_checks++; if (clk_out !== e_second) begin n_fail++; $display("FAIL rand_neg cyc=%0d got=%b exp=%b", cyc, clk_out, e_second); end
    end
    cfg_we = 1'b0; sync = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 3'b111; sync = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
    test_reset();
    test_odd_div();
    test_div_change();
    test_cfg_err();
    test_sync();
    test_rst_disable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
